// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multi-cycle RV32I control sequencer.
// Steps FETCH/DECODE/EXEC/MEM/WB over one shared datapath and one memory port,
// drives every datapath select line, and halts on a memory-handshake timeout.
// Optional feature macro: MC_ILLEGAL_TRAP_EN. When it is defined, unlisted opcodes
// set the sticky illegal_o flag and halt. When it is undefined, they retire as a NOP.
module mc_ctrl_fsm #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] inst_i,
  input  logic        br_taken_i,
  input  logic        mem_ack_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic        mem_addr_sel_o,
  output logic        ir_we_o,
  output logic        imm_we_o,
  output logic        alu_a_sel_o,
  output logic        alu_b_sel_o,
  output logic        rf_we_o,
  output logic [1:0]  wb_sel_o,
  output logic        pc_we_o,
  output logic [1:0]  pc_src_o,
  output logic        retire_o,
  output logic [2:0]  state_o,
  output logic        bus_err_o
`ifdef MC_ILLEGAL_TRAP_EN
  ,output logic       illegal_o
`endif
);

  localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT_CYC - 1);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd7
  } state_t;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       addr_sel;
    logic       ir_we;
    logic       imm_we;
    logic       alu_a;
    logic       alu_b;
    logic       rf_we;
    logic [1:0] wb_sel;
    logic       pc_we;
    logic [1:0] pc_src;
    logic       retire;
  } ctl_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
`ifdef MC_ILLEGAL_TRAP_EN
  logic          ill_q, ill_d;
`endif
  ctl_t          ctl, ctl_o;

  // Only the opcode field steers control; the other IR bits belong to the datapath.
  logic [6:0] op;
  logic       unused_inst;
  assign op          = inst_i[6:0];
  assign unused_inst = ^inst_i[31:7];

  logic is_r, is_i, is_ld, is_st, is_br, is_jal, is_jalr, is_lui, is_auipc, is_legal;
  assign is_r     = (op == OP_R);
  assign is_i     = (op == OP_I);
  assign is_ld    = (op == OP_LOAD);
  assign is_st    = (op == OP_STORE);
  assign is_br    = (op == OP_BR);
  assign is_jal   = (op == OP_JAL);
  assign is_jalr  = (op == OP_JALR);
  assign is_lui   = (op == OP_LUI);
  assign is_auipc = (op == OP_AUIPC);
  assign is_legal = is_r | is_i | is_ld | is_st | is_br | is_jal | is_jalr | is_lui | is_auipc;

  // ALU operand selects. They are held from EXEC through MEM/WB so the ALU result
  // stays stable while it is consumed as an address, a writeback value or a jump target.
  logic alu_a_pick, alu_b_pick;
  assign alu_a_pick = is_auipc;
  assign alu_b_pick = is_i | is_ld | is_st | is_jalr | is_auipc;

  // Next state, watchdog and sticky flags, plus the per-state control word.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    err_d   = err_q;
`ifdef MC_ILLEGAL_TRAP_EN
    ill_d   = ill_q;
`endif
    ctl     = '0;
    case (state_q)
      S_FETCH: begin
        ctl.mem_req = 1'b1;
        ctl.ir_we   = mem_ack_i;
        if (mem_ack_i) begin
          state_d = S_DECODE;
        end else if (cnt_q == WD_LAST) begin
          state_d = S_HALT;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DECODE: begin
        ctl.imm_we = 1'b1;
        state_d    = S_EXEC;
      end
      S_EXEC: begin
        ctl.alu_a = alu_a_pick;
        ctl.alu_b = alu_b_pick;
        if (is_br) begin
          ctl.pc_we  = 1'b1;
          ctl.pc_src = br_taken_i ? 2'd1 : 2'd0;
          ctl.retire = 1'b1;
          state_d    = S_FETCH;
        end else if (is_ld || is_st) begin
          state_d = S_MEM;
        end else if (is_legal) begin
          state_d = S_WB;
        end else begin
`ifdef MC_ILLEGAL_TRAP_EN
          ill_d   = 1'b1;
          state_d = S_HALT;
`else
          ctl.pc_we  = 1'b1;
          ctl.retire = 1'b1;
          state_d    = S_FETCH;
`endif
        end
      end
      S_MEM: begin
        ctl.mem_req  = 1'b1;
        ctl.addr_sel = 1'b1;
        ctl.mem_we   = is_st;
        ctl.alu_a    = alu_a_pick;
        ctl.alu_b    = alu_b_pick;
        if (mem_ack_i) begin
          if (is_st) begin
            ctl.pc_we  = 1'b1;
            ctl.retire = 1'b1;
            state_d    = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (cnt_q == WD_LAST) begin
          state_d = S_HALT;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WB: begin
        ctl.alu_a  = alu_a_pick;
        ctl.alu_b  = alu_b_pick;
        ctl.rf_we  = 1'b1;
        ctl.pc_we  = 1'b1;
        ctl.retire = 1'b1;
        if (is_ld)                 ctl.wb_sel = 2'd1;
        else if (is_jal || is_jalr) ctl.wb_sel = 2'd2;
        else if (is_lui)           ctl.wb_sel = 2'd3;
        if (is_jal)       ctl.pc_src = 2'd1;
        else if (is_jalr) ctl.pc_src = 2'd2;
        state_d = S_FETCH;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  // State, watchdog counter and sticky error flags.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
      err_q   <= 1'b0;
`ifdef MC_ILLEGAL_TRAP_EN
      ill_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`ifdef MC_ILLEGAL_TRAP_EN
      ill_q   <= ill_d;
`endif
    end
  end

  // Every output is forced low while reset is asserted. This drops an in-flight
  // request and ignores an ack that arrives during the reset cycle.
  assign ctl_o          = rst_i ? '0 : ctl;
  assign mem_req_o      = ctl_o.mem_req;
  assign mem_we_o       = ctl_o.mem_we;
  assign mem_addr_sel_o = ctl_o.addr_sel;
  assign ir_we_o        = ctl_o.ir_we;
  assign imm_we_o       = ctl_o.imm_we;
  assign alu_a_sel_o    = ctl_o.alu_a;
  assign alu_b_sel_o    = ctl_o.alu_b;
  assign rf_we_o        = ctl_o.rf_we;
  assign wb_sel_o       = ctl_o.wb_sel;
  assign pc_we_o        = ctl_o.pc_we;
  assign pc_src_o       = ctl_o.pc_src;
  assign retire_o       = ctl_o.retire;
  assign state_o        = rst_i ? 3'd0 : state_q;
  assign bus_err_o      = rst_i ? 1'b0 : err_q;
`ifdef MC_ILLEGAL_TRAP_EN
  assign illegal_o      = rst_i ? 1'b0 : ill_q;
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed-vector bench for mc_ctrl_fsm (TIMEOUT_CYC = 4).
// Outputs are packed as {req, we, addr_sel, ir_we, imm_we, a, b, rf_we, wb_sel, pc_we, pc_src, retire, state, bus_err}.
module tb_mc_ctrl_fsm;
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [31:0] inst_i = '0;
  logic        br_taken_i = 1'b0;
  logic        mem_ack_i = 1'b0;
  logic        mem_req_o, mem_we_o, mem_addr_sel_o, ir_we_o, imm_we_o;
  logic        alu_a_sel_o, alu_b_sel_o, rf_we_o, pc_we_o, retire_o, bus_err_o;
  logic [1:0]  wb_sel_o, pc_src_o;
  logic [2:0]  state_o;
`ifdef MC_ILLEGAL_TRAP_EN
  logic        illegal_o;
`endif

  mc_ctrl_fsm #(.TIMEOUT_CYC(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .inst_i(inst_i), .br_taken_i(br_taken_i),
    .mem_ack_i(mem_ack_i), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_sel_o(mem_addr_sel_o), .ir_we_o(ir_we_o), .imm_we_o(imm_we_o),
    .alu_a_sel_o(alu_a_sel_o), .alu_b_sel_o(alu_b_sel_o), .rf_we_o(rf_we_o),
    .wb_sel_o(wb_sel_o), .pc_we_o(pc_we_o), .pc_src_o(pc_src_o),
    .retire_o(retire_o), .state_o(state_o), .bus_err_o(bus_err_o)
`ifdef MC_ILLEGAL_TRAP_EN
    , .illegal_o(illegal_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  logic [17:0] obs;
  assign obs = {mem_req_o, mem_we_o, mem_addr_sel_o, ir_we_o, imm_we_o, alu_a_sel_o,
                alu_b_sel_o, rf_we_o, wb_sel_o, pc_we_o, pc_src_o, retire_o, state_o, bus_err_o};

  int n_vec = 0;
  int n_err = 0;
  logic [17:0] F_WAIT, F_ACK, DEC, M_LD, ZERO;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %05h expected %05h", tag, got, exp);
    end
  endtask

  function automatic logic [17:0] ev(input logic req, we, as, ir, imm, a, b, rf,
                                     input logic [1:0] wb, input logic pcwe,
                                     input logic [1:0] ps, input logic ret,
                                     input logic [2:0] st, input logic err);
    return {req, we, as, ir, imm, a, b, rf, wb, pcwe, ps, ret, st, err};
  endfunction

  // Advance one clock; inputs default low for the new cycle.
  task automatic tick();
    @(posedge clk_i);
    #1;
    mem_ack_i  = 1'b0;
    br_taken_i = 1'b0;
  endtask

  task automatic cv(input string tag, input logic [17:0] exp);
    #1;
    chk(tag, {14'b0, obs}, {14'b0, exp});
  endtask

  // From the first FETCH cycle, run the given wait cycles, ack and DECODE; return in EXEC.
  task automatic do_fetch(input logic [31:0] ins, input int waits);
    for (int i = 0; i < waits; i++) begin
      cv("fetch_wait", F_WAIT);
      tick();
    end
    mem_ack_i = 1'b1;
    inst_i    = ins;
    cv("fetch_ack", F_ACK);
    tick();
    cv("decode", DEC);
    tick();
  endtask

  task automatic run_wb(input string tag, input logic [31:0] ins, input int waits,
                        input logic [17:0] e_exec, input logic [17:0] e_wb);
    do_fetch(ins, waits);
    cv({tag, "_exec"}, e_exec);
    tick();
    cv({tag, "_wb"}, e_wb);
    tick();
    cv({tag, "_next"}, F_WAIT);
  endtask

  initial begin
    F_WAIT = ev(1,0,0,0,0,0,0,0,2'd0,0,2'd0,0,3'd0,0);
    F_ACK  = ev(1,0,0,1,0,0,0,0,2'd0,0,2'd0,0,3'd0,0);
    DEC    = ev(0,0,0,0,1,0,0,0,2'd0,0,2'd0,0,3'd1,0);
    M_LD   = ev(1,0,1,0,0,0,1,0,2'd0,0,2'd0,0,3'd3,0);
    ZERO   = '0;

    // Reset: outputs zero even with an ack present.
    tick();
    tick();
    mem_ack_i = 1'b1;
    cv("rst_zero", ZERO);
    tick();
    rst_i = 1'b0;
    cv("post_rst_fetch", F_WAIT);
`ifdef MC_ILLEGAL_TRAP_EN
    chk("illegal_rst", {31'b0, illegal_o}, 32'd0);
`endif

    // ADDI, ack on 3rd FETCH cycle: 6 cycles total.
    run_wb("addi", 32'h00500093, 2,
           ev(0,0,0,0,0,0,1,0,2'd0,0,2'd0,0,3'd2,0),
           ev(0,0,0,0,0,0,1,1,2'd0,1,2'd0,1,3'd4,0));

    // BEQ taken / not taken: retire in EXEC, straight back to FETCH.
    do_fetch(32'h00208463, 0);
    br_taken_i = 1'b1;
    cv("beq_t_exec", ev(0,0,0,0,0,0,0,0,2'd0,1,2'd1,1,3'd2,0));
    tick();
    cv("beq_t_next", F_WAIT);
    do_fetch(32'h00208463, 0);
    cv("beq_nt_exec", ev(0,0,0,0,0,0,0,0,2'd0,1,2'd0,1,3'd2,0));
    tick();
    cv("beq_nt_next", F_WAIT);

    // LW: three MEM cycles with ack on the third, then WB from memory.
    do_fetch(32'h00002083, 0);
    cv("lw_exec", ev(0,0,0,0,0,0,1,0,2'd0,0,2'd0,0,3'd2,0));
    tick();
    for (int i = 0; i < 2; i++) begin
      cv("lw_mem_wait", M_LD);
      tick();
    end
    mem_ack_i = 1'b1;
    cv("lw_mem_ack", M_LD);
    tick();
    cv("lw_wb", ev(0,0,0,0,0,0,1,1,2'd1,1,2'd0,1,3'd4,0));
    tick();
    cv("lw_next", F_WAIT);

    // SW: store write until ack, retire in MEM, no WB.
    do_fetch(32'h00102023, 0);
    cv("sw_exec", ev(0,0,0,0,0,0,1,0,2'd0,0,2'd0,0,3'd2,0));
    tick();
    cv("sw_mem_wait", ev(1,1,1,0,0,0,1,0,2'd0,0,2'd0,0,3'd3,0));
    tick();
    mem_ack_i = 1'b1;
    cv("sw_mem_ack", ev(1,1,1,0,0,0,1,0,2'd0,1,2'd0,1,3'd3,0));
    tick();
    cv("sw_next", F_WAIT);

    // Writeback-class opcodes.
    run_wb("jal", 32'h008000EF, 0,
           ev(0,0,0,0,0,0,0,0,2'd0,0,2'd0,0,3'd2,0),
           ev(0,0,0,0,0,0,0,1,2'd2,1,2'd1,1,3'd4,0));
    run_wb("jalr", 32'h000080E7, 0,
           ev(0,0,0,0,0,0,1,0,2'd0,0,2'd0,0,3'd2,0),
           ev(0,0,0,0,0,0,1,1,2'd2,1,2'd2,1,3'd4,0));
    run_wb("lui", 32'h123450B7, 0,
           ev(0,0,0,0,0,0,0,0,2'd0,0,2'd0,0,3'd2,0),
           ev(0,0,0,0,0,0,0,1,2'd3,1,2'd0,1,3'd4,0));
    run_wb("auipc", 32'h00001097, 0,
           ev(0,0,0,0,0,1,1,0,2'd0,0,2'd0,0,3'd2,0),
           ev(0,0,0,0,0,1,1,1,2'd0,1,2'd0,1,3'd4,0));
    run_wb("add", 32'h002081B3, 0,
           ev(0,0,0,0,0,0,0,0,2'd0,0,2'd0,0,3'd2,0),
           ev(0,0,0,0,0,0,0,1,2'd0,1,2'd0,1,3'd4,0));

    // Unlisted opcode 0x7F.
    do_fetch(32'h0000007F, 0);
`ifdef MC_ILLEGAL_TRAP_EN
    cv("ill_exec", ev(0,0,0,0,0,0,0,0,2'd0,0,2'd0,0,3'd2,0));
    tick();
    cv("ill_halt", ev(0,0,0,0,0,0,0,0,2'd0,0,2'd0,0,3'd7,0));
    chk("illegal_set", {31'b0, illegal_o}, 32'd1);
    tick();
    mem_ack_i = 1'b1;
    cv("ill_halt_held", ev(0,0,0,0,0,0,0,0,2'd0,0,2'd0,0,3'd7,0));
`else
    cv("ill_nop", ev(0,0,0,0,0,0,0,0,2'd0,1,2'd0,1,3'd2,0));
    tick();
    cv("ill_next", F_WAIT);
`endif
    rst_i = 1'b1;
    cv("rst2_zero", ZERO);
    tick();
    rst_i = 1'b0;
    cv("rst2_fetch", F_WAIT);
`ifdef MC_ILLEGAL_TRAP_EN
    chk("illegal_clr", {31'b0, illegal_o}, 32'd0);
`endif

    // Reset during MEM with an ack in the reset cycle: request drops and the ack is ignored.
    do_fetch(32'h00002083, 0);
    tick();
    cv("rmem_pre", M_LD);
    rst_i     = 1'b1;
    mem_ack_i = 1'b1;
    cv("rmem_rst_cycle", ZERO);
    tick();
    cv("rmem_next", ZERO);
    rst_i = 1'b0;
    cv("rmem_fetch", F_WAIT);

    // Watchdog: ack on the 4th request cycle wins.
    run_wb("wd_ack", 32'h00500093, 3,
           ev(0,0,0,0,0,0,1,0,2'd0,0,2'd0,0,3'd2,0),
           ev(0,0,0,0,0,0,1,1,2'd0,1,2'd0,1,3'd4,0));

    // Watchdog: four request cycles with no ack lead to HALT, with bus_err sticky.
    for (int i = 0; i < 4; i++) begin
      cv("wd_wait", F_WAIT);
      tick();
    end
    cv("wd_halt", ev(0,0,0,0,0,0,0,0,2'd0,0,2'd0,0,3'd7,1));
    tick();
    mem_ack_i = 1'b1;
    cv("wd_halt_held", ev(0,0,0,0,0,0,0,0,2'd0,0,2'd0,0,3'd7,1));
    tick();
    cv("wd_halt_held2", ev(0,0,0,0,0,0,0,0,2'd0,0,2'd0,0,3'd7,1));
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    cv("wd_clr", F_WAIT);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
